// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, coordinate/colour widths and pixel type
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 4;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one scan axis: wrapping position counter with sync and visible decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = VGA_H_TOTAL,
  parameter int VISIBLE    = VGA_H_VISIBLE,
  parameter int SYNC_START = VGA_H_VISIBLE + VGA_H_FP,
  parameter int SYNC_LEN   = VGA_H_SYNC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               sync_n,
  output logic               in_visible
);

  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] VIS_END    = COORD_W'(VISIBLE);
  localparam logic [COORD_W-1:0] SYNC_FIRST = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SYNC_LAST  = COORD_W'(SYNC_START + SYNC_LEN - 1);

  // wrap is qualified by en so it can directly enable the next axis
  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign sync_n     = !((count >= SYNC_FIRST) && (count <= SYNC_LAST));
  assign in_visible = (count < VIS_END);

endmodule

// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA scan counters, blank-gated registered RGB and syncs; VGA_BORDER_TEST_EN forces a white border
module vga_scan_driver
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int CLK_DIV   = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [COLOR_W-1:0] Red_in,
  input  logic [COLOR_W-1:0] Green_in,
  input  logic [COLOR_W-1:0] Blue_in,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               pixel_en,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               hs,
  output logic               vs,
  output logic               blank_n,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] Y_LAST_VIS = COORD_W'(V_VISIBLE - 1);

  logic [DIV_W-1:0] div;
  logic             h_wrap, h_sync_n, h_vis;
  logic             v_sync_n, v_vis;
  logic             vis;
  rgb_t             pix_in, pix_d, pix_q;

  // pixel_en is registered so it stays low through reset, even with CLK_DIV=1
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div      <= '0;
      pixel_en <= 1'b0;
    end else begin
      div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
      pixel_en <= (div == DIV_LAST);
    end
  end

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .en         (pixel_en),
    .count      (DrawX),
    .wrap       (h_wrap),
    .sync_n     (h_sync_n),
    .in_visible (h_vis)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .en         (h_wrap),
    .count      (DrawY),
    .wrap       (),
    .sync_n     (v_sync_n),
    .in_visible (v_vis)
  );

  assign vis    = h_vis && v_vis;
  assign pix_in = {Red_in, Green_in, Blue_in};

`ifdef VGA_BORDER_TEST_EN
  localparam logic [COORD_W-1:0] X_LAST_VIS = COORD_W'(H_VISIBLE - 1);
  logic border;
  assign border = (DrawX == '0) || (DrawX == X_LAST_VIS) || (DrawY == '0) || (DrawY == Y_LAST_VIS);
  assign pix_d  = !vis ? '0 : (border ? '1 : pix_in);
`else
  assign pix_d  = vis ? pix_in : '0;
`endif

  // colour and syncs share one register stage so they stay co-aligned
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_q       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= h_wrap && (DrawY == Y_LAST_VIS);
      if (pixel_en) begin
        pix_q   <= pix_d;
        hs      <= h_sync_n;
        vs      <= v_sync_n;
        blank_n <= vis;
      end
    end
  end

  assign VGA_R = pix_q.r;
  assign VGA_G = pix_q.g;
  assign VGA_B = pix_q.b;

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb/tb_vga_scan_driver.sv - self-checking bench for vga_scan_driver on a reduced raster
module tb_vga_scan_driver;

  localparam int HV = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VV = 6,  VFP = 2, VS = 2, VBP = 2;
  localparam int DIV = 2;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int LINE_CLK  = HT * DIV;
  localparam int FRAME_CLK = HT * VT * DIV;
`ifdef VGA_BORDER_TEST_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Red_in = '0, Green_in = '0, Blue_in = '0;
  logic [9:0] DrawX, DrawY;
  logic       pixel_en, hs, vs, blank_n, frame_start;
  logic [3:0] VGA_R, VGA_G, VGA_B;

  vga_scan_driver #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(DIV)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
    .DrawX(DrawX), .DrawY(DrawY), .pixel_en(pixel_en),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .hs(hs), .vs(vs), .blank_n(blank_n), .frame_start(frame_start)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // input driver: random colours every Clk, or a fixed colour for table vectors
  bit         rand_rgb = 1'b1;
  logic [11:0] fix_rgb = '0;
  always @(posedge Clk) begin
    #1;
    if (rand_rgb) {Red_in, Green_in, Blue_in} = 12'($urandom);
    else          {Red_in, Green_in, Blue_in} = fix_rgb;
  end

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
  } out_t;

  function automatic out_t exp_out(input int x, input int y, input logic [11:0] in_rgb);
    out_t o;
    bit vis, border;
    vis    = (x < HV) && (y < VV);
    border = BORDER_EN && (x == 0 || x == HV - 1 || y == 0 || y == VV - 1);
    o.rgb   = !vis ? 12'h000 : (border ? 12'hFFF : in_rgb);
    o.hs    = !(x >= HV + HFP && x <= HV + HFP + HS - 1);
    o.vs    = !(y >= VV + VFP && y <= VV + VFP + VS - 1);
    o.blank = vis;
    return o;
  endfunction

  // scoreboard: expectation pushed on each strobe, popped once the DUT registers it
  out_t sb_q[$];
  out_t cur_exp;
  int   mx, my, gap;
  bit   pop_due, fs_due, seen_pe;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      sb_q.delete();
      mx = 0; my = 0; gap = 0;
      pop_due = 0; fs_due = 0; seen_pe = 0;
      cur_exp = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, blank: 1'b0};
    end else begin
      if (pop_due) begin
        cur_exp = sb_q.pop_front();
        pop_due = 0;
      end
      check("sb_rgb",   {VGA_R, VGA_G, VGA_B}, cur_exp.rgb);
      check("sb_hs",    hs, cur_exp.hs);
      check("sb_vs",    vs, cur_exp.vs);
      check("sb_blank", blank_n, cur_exp.blank);
      check("sb_frame_start", frame_start, fs_due);
      check("sb_drawx", DrawX, mx);
      check("sb_drawy", DrawY, my);
      gap++;
      fs_due = 0;
      if (pixel_en) begin
        if (seen_pe) check("pixel_en_period", gap, DIV);
        seen_pe = 1; gap = 0;
        sb_q.push_back(exp_out(mx, my, {Red_in, Green_in, Blue_in}));
        pop_due = 1;
        fs_due  = (mx == HT - 1) && (my == VV - 1);
        if (mx == HT - 1) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
    end
  end

  typedef struct {
    int          x, y;
    logic [11:0] in_rgb;
    logic [11:0] rgb;
    logic        hs, vs, blank;
    bit          border;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int cnt, t0;
    bit ok;
    logic prev;

    vecs[0]  = '{x: 1,  y: 1,  in_rgb: 12'h000, rgb: 12'h000, hs: 1, vs: 1, blank: 1, border: 0};
    vecs[1]  = '{x: 5,  y: 2,  in_rgb: 12'hA53, rgb: 12'hA53, hs: 1, vs: 1, blank: 1, border: 0};
    vecs[2]  = '{x: 15, y: 3,  in_rgb: 12'h123, rgb: 12'h123, hs: 1, vs: 1, blank: 1, border: 1};
    vecs[3]  = '{x: 16, y: 3,  in_rgb: 12'h777, rgb: 12'h000, hs: 1, vs: 1, blank: 0, border: 0};
    vecs[4]  = '{x: 18, y: 3,  in_rgb: 12'h777, rgb: 12'h000, hs: 0, vs: 1, blank: 0, border: 0};
    vecs[5]  = '{x: 20, y: 3,  in_rgb: 12'h777, rgb: 12'h000, hs: 0, vs: 1, blank: 0, border: 0};
    vecs[6]  = '{x: 21, y: 3,  in_rgb: 12'h777, rgb: 12'h000, hs: 1, vs: 1, blank: 0, border: 0};
    vecs[7]  = '{x: 7,  y: 5,  in_rgb: 12'hCCC, rgb: 12'hCCC, hs: 1, vs: 1, blank: 1, border: 1};
    vecs[8]  = '{x: 5,  y: 6,  in_rgb: 12'h777, rgb: 12'h000, hs: 1, vs: 1, blank: 0, border: 0};
    vecs[9]  = '{x: 5,  y: 8,  in_rgb: 12'h777, rgb: 12'h000, hs: 1, vs: 0, blank: 0, border: 0};
    vecs[10] = '{x: 5,  y: 9,  in_rgb: 12'h777, rgb: 12'h000, hs: 1, vs: 0, blank: 0, border: 0};
    vecs[11] = '{x: 5,  y: 10, in_rgb: 12'h777, rgb: 12'h000, hs: 1, vs: 1, blank: 0, border: 0};
    vecs[12] = '{x: 0,  y: 0,  in_rgb: 12'hA53, rgb: 12'hA53, hs: 1, vs: 1, blank: 1, border: 1};

    // reset held for 5 Clk
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    check("rst_drawx", DrawX, 0);
    check("rst_drawy", DrawY, 0);
    check("rst_pixel_en", pixel_en, 0);
    check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_blank_n", blank_n, 0);
    check("rst_frame_start", frame_start, 0);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    check("first_pe_clk1", pixel_en, 0);
    @(negedge Clk);
    check("first_pe_clk2", pixel_en, 1);
    check("first_pe_drawx", DrawX, 0);

    // table vectors
    foreach (vecs[i]) begin
      rand_rgb = 1'b0;
      fix_rgb  = vecs[i].in_rgb;
      repeat (2) @(negedge Clk);
      ok = 0;
      for (int k = 0; k < 2 * FRAME_CLK; k++) begin
        @(negedge Clk);
        if (pixel_en && DrawX == 10'(vecs[i].x) && DrawY == 10'(vecs[i].y)) begin
          ok = 1;
          break;
        end
      end
      check($sformatf("vec%0d_reached", i), ok, 1);
      @(negedge Clk);
      check($sformatf("vec%0d_rgb", i), {VGA_R, VGA_G, VGA_B},
            (BORDER_EN && vecs[i].border) ? 12'hFFF : vecs[i].rgb);
      check($sformatf("vec%0d_hs", i), hs, vecs[i].hs);
      check($sformatf("vec%0d_vs", i), vs, vecs[i].vs);
      check($sformatf("vec%0d_blank_n", i), blank_n, vecs[i].blank);
    end
    rand_rgb = 1'b1;

    // line timing: hs falls one pixel after DrawX reaches the sync start
    ok = 0; prev = hs;
    for (int k = 0; k < 2 * LINE_CLK; k++) begin
      @(negedge Clk);
      if (prev && !hs) begin ok = 1; break; end
      prev = hs;
    end
    check("hs_fall_found", ok, 1);
    check("hs_fall_drawx", DrawX, HV + HFP + 1);
    cnt = 0;
    while (!hs && cnt < 4 * LINE_CLK) begin cnt++; @(negedge Clk); end
    check("hs_low_clk", cnt, HS * DIV);
    t0 = cnt; prev = hs;
    for (int k = 0; k < 2 * LINE_CLK; k++) begin
      @(negedge Clk);
      t0++;
      if (prev && !hs) break;
      prev = hs;
    end
    check("line_period_clk", t0, LINE_CLK);

    // frame timing
    ok = 0; prev = vs;
    for (int k = 0; k < 2 * FRAME_CLK; k++) begin
      @(negedge Clk);
      if (prev && !vs) begin ok = 1; break; end
      prev = vs;
    end
    check("vs_fall_found", ok, 1);
    cnt = 0;
    while (!vs && cnt < 4 * FRAME_CLK) begin cnt++; @(negedge Clk); end
    check("vs_low_clk", cnt, VS * LINE_CLK);
    ok = 0;
    for (int k = 0; k < 2 * FRAME_CLK; k++) begin
      @(negedge Clk);
      if (frame_start) begin ok = 1; break; end
    end
    check("frame_start_found", ok, 1);
    check("frame_start_drawy", DrawY, VV);
    cnt = 0;
    for (int k = 0; k < 2 * FRAME_CLK; k++) begin
      @(negedge Clk);
      cnt++;
      if (frame_start) break;
    end
    check("frame_period_clk", cnt, FRAME_CLK);

    // reset mid-frame with a visible colour on the pins
    rand_rgb = 1'b0;
    fix_rgb  = 12'hA53;
    ok = 0;
    for (int k = 0; k < 2 * FRAME_CLK; k++) begin
      @(negedge Clk);
      if (DrawX == 10'd5 && DrawY == 10'd3 && !pixel_en) begin ok = 1; break; end
    end
    check("midrst_reached", ok, 1);
    check("midrst_pre_rgb", {VGA_R, VGA_G, VGA_B}, 12'hA53);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    check("midrst_hs", hs, 1);
    check("midrst_vs", vs, 1);
    check("midrst_blank_n", blank_n, 0);
    check("midrst_drawx", DrawX, 0);
    check("midrst_drawy", DrawY, 0);
    check("midrst_pixel_en", pixel_en, 0);
    repeat (3) @(negedge Clk);
    #1 Reset_n = 1'b1;
    rand_rgb = 1'b1;
    cnt = 0;
    for (int k = 0; k < 2 * FRAME_CLK; k++) begin
      @(negedge Clk);
      cnt++;
      if (frame_start) break;
    end
    check("midrst_first_frame_start_clk", cnt, 2 * HT * VV + 1);
    check("midrst_frame_start_drawy", DrawY, VV);

    repeat (4) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
